acq_track_scheduler: RTL and testbench

- Sits between the acquisition engine and the tracking channels.
- Sequences acquisition runs and latches the four acquired results on completion.
- Dispatches each valid result to a free tracking channel and frees channels on lock loss.
- Round-robin arbitrates the single tracking read port of the sample memory among the tracking channels.

---
 rtl/acq_track_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_acq_track_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_track_scheduler.sv
// Acquisition/tracking scheduler: runs acquisitions, dispatches results to free tracking
// channels, and round-robin arbitrates the sample-memory tracking read port.
// Optional build macro DUP_FILTER_EN: skip PRNs already tracked or dispatched in this scan.
module acq_track_scheduler #(
  parameter int NUM_TRK = 4,
  parameter int PRN_W   = 5,
  parameter int CP_W    = 11,
  parameter int CARR_W  = 32,
  parameter int PTR_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     acq_start,
  input  logic                     acq_complete,
  input  logic [4*PRN_W-1:0]       acq_prn,
  input  logic [4*CP_W-1:0]        acq_code,
  input  logic [4*CARR_W-1:0]      acq_carr,
  output logic [NUM_TRK-1:0]       trk_load,
  output logic [PRN_W-1:0]         trk_prn,
  output logic [CP_W-1:0]          trk_code,
  output logic [CARR_W-1:0]        trk_carr,
  input  logic [NUM_TRK-1:0]       trk_release,
  output logic [NUM_TRK-1:0]       trk_busy,
  input  logic [NUM_TRK-1:0]       trk_req,
  input  logic [NUM_TRK*PTR_W-1:0] trk_ptr,
  output logic [PTR_W-1:0]         mem_ptr,
  output logic [NUM_TRK-1:0]       mem_gnt,
  output logic [NUM_TRK-1:0]       trk_dvalid
);
  localparam int IDX_W = $clog2(NUM_TRK);

  typedef enum logic [1:0] {S_START, S_WAIT, S_SCAN, S_FULL} state_t;

  state_t              state, state_nxt;
  logic [1:0]          idx;
  logic                armed;
  logic                complete_d, complete_rise;
  logic [PRN_W-1:0]    slot_prn  [4];
  logic [CP_W-1:0]     slot_code [4];
  logic [CARR_W-1:0]   slot_carr [4];
  logic [PRN_W-1:0]    prn_q;
  logic [CP_W-1:0]     code_q;
  logic [CARR_W-1:0]   carr_q;
  logic [NUM_TRK-1:0]  busy, free_oh, load_oh;
  logic                any_free, start_req, latch_slots, dispatch, dup_hit;

  assign any_free = ~&busy;

  // Lowest-index free channel, as a one-hot vector.
  always_comb begin
    free_oh = '0;
    for (int i = NUM_TRK - 1; i >= 0; i--)
      if (!busy[i]) free_oh = NUM_TRK'(1) << i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      complete_d    <= 1'b0;
      complete_rise <= 1'b0;
    end else begin
      complete_d    <= acq_complete;
      complete_rise <= acq_complete & ~complete_d;
    end
  end

  // NOTE: slot registers carry no reset; S_SCAN only reads them after S_WAIT has loaded them.
  always_ff @(posedge clk) begin
    if (latch_slots) begin
      for (int s = 0; s < 4; s++) begin
        slot_prn[s]  <= acq_prn[s*PRN_W +: PRN_W];
        slot_code[s] <= acq_code[s*CP_W +: CP_W];
        slot_carr[s] <= acq_carr[s*CARR_W +: CARR_W];
      end
    end
  end

`ifdef DUP_FILTER_EN
  logic [PRN_W-1:0] chan_prn [NUM_TRK];
  logic [3:0]       sent;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_TRK; i++)
      if (load_oh[i]) chan_prn[i] <= slot_prn[idx];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           sent <= '0;
    else if (latch_slots) sent <= '0;
    else if (dispatch)    sent[idx] <= 1'b1;
  end

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < NUM_TRK; i++)
      if (busy[i] && chan_prn[i] == slot_prn[idx]) dup_hit = 1'b1;
    for (int s = 0; s < 4; s++)
      if (sent[s] && slot_prn[s] == slot_prn[idx]) dup_hit = 1'b1;
  end
`else
  assign dup_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    start_req   = 1'b0;
    latch_slots = 1'b0;
    dispatch    = 1'b0;
    case (state)
      S_START: begin
        // armed holds off the launch pulse until the first clock after reset release.
        if (armed) begin
          if (any_free) begin
            start_req = 1'b1;
            state_nxt = S_WAIT;
          end else begin
            state_nxt = S_FULL;
          end
        end
      end
      S_WAIT: begin
        if (complete_rise) begin
          latch_slots = 1'b1;
          state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
        dispatch = any_free && (slot_prn[idx] != '0) && !dup_hit;
        if (idx == 2'd3)   state_nxt = S_START;
        else if (!any_free) state_nxt = S_FULL;
      end
      S_FULL: begin
        if (any_free) state_nxt = S_START;
      end
      default: state_nxt = S_START;
    endcase
  end

  assign load_oh   = dispatch ? free_oh : '0;
  assign trk_load  = load_oh;
  assign trk_busy  = busy;
  assign acq_start = start_req;
  assign trk_prn   = dispatch ? slot_prn[idx]  : prn_q;
  assign trk_code  = dispatch ? slot_code[idx] : code_q;
  assign trk_carr  = dispatch ? slot_carr[idx] : carr_q;

  // NOTE: non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_START;
      armed  <= 1'b0;
      idx    <= '0;
      busy   <= '0;
      prn_q  <= '0;
      code_q <= '0;
      carr_q <= '0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
      if (latch_slots)          idx <= '0;
      else if (state == S_SCAN) idx <= idx + 2'd1;
      // A load only ever targets an idle channel, so it cannot collide with a real release.
      busy <= (busy & ~trk_release) | load_oh;
      if (dispatch) begin
        prn_q  <= slot_prn[idx];
        code_q <= slot_code[idx];
        carr_q <= slot_carr[idx];
      end
    end
  end

  // Round-robin memory arbiter: first requester at or after rr_ptr, wrapping.
  logic [IDX_W-1:0] rr_ptr, gnt_idx, cand;
  logic             gnt_found;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = rr_ptr;
    cand      = rr_ptr;
    for (int k = 0; k < NUM_TRK; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_TRK);
      if (!gnt_found && trk_req[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      mem_gnt    <= '0;
      mem_ptr    <= '0;
      trk_dvalid <= '0;
    end else begin
      trk_dvalid <= mem_gnt;
      mem_gnt    <= '0;
      if (gnt_found) begin
        mem_gnt <= NUM_TRK'(1) << gnt_idx;
        mem_ptr <= trk_ptr[gnt_idx*PTR_W +: PTR_W];
        rr_ptr  <= (gnt_idx == IDX_W'(NUM_TRK - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acq_track_scheduler.sv
// Self-checking bench for acq_track_scheduler: arbiter vector table plus a load scoreboard
// driven by hand-written acquisition/release/reset sequences.
module tb_acq_track_scheduler;
  localparam int NUM_TRK = 4;
  localparam int PRN_W   = 5;
  localparam int CP_W    = 11;
  localparam int CARR_W  = 32;
  localparam int PTR_W   = 16;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     acq_start;
  logic                     acq_complete;
  logic [4*PRN_W-1:0]       acq_prn;
  logic [4*CP_W-1:0]        acq_code;
  logic [4*CARR_W-1:0]      acq_carr;
  logic [NUM_TRK-1:0]       trk_load;
  logic [PRN_W-1:0]         trk_prn;
  logic [CP_W-1:0]          trk_code;
  logic [CARR_W-1:0]        trk_carr;
  logic [NUM_TRK-1:0]       trk_release;
  logic [NUM_TRK-1:0]       trk_busy;
  logic [NUM_TRK-1:0]       trk_req;
  logic [NUM_TRK*PTR_W-1:0] trk_ptr;
  logic [PTR_W-1:0]         mem_ptr;
  logic [NUM_TRK-1:0]       mem_gnt;
  logic [NUM_TRK-1:0]       trk_dvalid;

  always #5 clk = ~clk;

  acq_track_scheduler #(
    .NUM_TRK(NUM_TRK), .PRN_W(PRN_W), .CP_W(CP_W), .CARR_W(CARR_W), .PTR_W(PTR_W)
  ) dut (
    .clk(clk), .reset(reset), .acq_start(acq_start), .acq_complete(acq_complete),
    .acq_prn(acq_prn), .acq_code(acq_code), .acq_carr(acq_carr),
    .trk_load(trk_load), .trk_prn(trk_prn), .trk_code(trk_code), .trk_carr(trk_carr),
    .trk_release(trk_release), .trk_busy(trk_busy), .trk_req(trk_req), .trk_ptr(trk_ptr),
    .mem_ptr(mem_ptr), .mem_gnt(mem_gnt), .trk_dvalid(trk_dvalid)
  );

  typedef struct {
    logic [NUM_TRK-1:0] load;
    logic [PRN_W-1:0]   prn;
    logic [CP_W-1:0]    code;
    logic [CARR_W-1:0]  carr;
  } load_t;

  typedef struct {
    logic [NUM_TRK-1:0] req;
    logic [NUM_TRK-1:0] gnt;
    logic [PTR_W-1:0]   ptr;
  } arb_vec_t;

  load_t    exp_q [$];
  arb_vec_t arb_tbl [12];
  int       errors = 0;
  int       checks = 0;
  int       start_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CP_W-1:0] code_of(input int s, input int p);
    return CP_W'(p * 37 + s * 5 + 100);
  endfunction

  function automatic logic [CARR_W-1:0] carr_of(input int s, input int p);
    return 32'hA500_0000 + CARR_W'(p * 256 + s);
  endfunction

  // Scoreboard side: every observed load pops and checks the oldest expectation.
  always @(negedge clk) begin
    load_t e;
    if (acq_start === 1'b1) start_cnt++;
    if (trk_load !== '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_load", 64'(trk_load), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("load_onehot", 64'(trk_load), 64'(e.load));
        check("load_prn", 64'(trk_prn), 64'(e.prn));
        check("load_code", 64'(trk_code), 64'(e.code));
        check("load_carr", 64'(trk_carr), 64'(e.carr));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_results(input int p0, input int p1, input int p2, input int p3);
    int p [4] = '{p0, p1, p2, p3};
    for (int s = 0; s < 4; s++) begin
      acq_prn[s*PRN_W +: PRN_W]    = PRN_W'(p[s]);
      acq_code[s*CP_W +: CP_W]     = code_of(s, p[s]);
      acq_carr[s*CARR_W +: CARR_W] = carr_of(s, p[s]);
    end
  endtask

  task automatic expect_load(input logic [NUM_TRK-1:0] oh, input int s, input int p);
    load_t e;
    e.load = oh;
    e.prn  = PRN_W'(p);
    e.code = code_of(s, p);
    e.carr = carr_of(s, p);
    exp_q.push_back(e);
  endtask

  task automatic wait_loads(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_start(input string name, input int budget);
    int n = 0;
    while (acq_start !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    check(name, 64'(acq_start), 64'd1);
    cyc();
    check({name, "_pulse_end"}, 64'(acq_start), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NUM_TRK-1:0] prev_gnt;

    acq_complete = 1'b0;
    acq_prn      = '0;
    acq_code     = '0;
    acq_carr     = '0;
    trk_release  = '0;
    trk_req      = '0;
    for (int i = 0; i < NUM_TRK; i++)
      trk_ptr[i*PTR_W +: PTR_W] = 16'h1000 + PTR_W'(i * 16'h0111);

    arb_tbl[0]  = '{4'b1111, 4'b0001, 16'h1000};
    arb_tbl[1]  = '{4'b1111, 4'b0010, 16'h1111};
    arb_tbl[2]  = '{4'b1111, 4'b0100, 16'h1222};
    arb_tbl[3]  = '{4'b1111, 4'b1000, 16'h1333};
    arb_tbl[4]  = '{4'b1111, 4'b0001, 16'h1000};
    arb_tbl[5]  = '{4'b0000, 4'b0000, 16'h1000};
    arb_tbl[6]  = '{4'b0001, 4'b0001, 16'h1000};
    arb_tbl[7]  = '{4'b0001, 4'b0001, 16'h1000};
    arb_tbl[8]  = '{4'b1001, 4'b1000, 16'h1333};
    arb_tbl[9]  = '{4'b1001, 4'b0001, 16'h1000};
    arb_tbl[10] = '{4'b0110, 4'b0010, 16'h1111};
    arb_tbl[11] = '{4'b0000, 4'b0000, 16'h1111};

    // Reset values.
    repeat (3) cyc();
    check("rst_acq_start", 64'(acq_start), 64'd0);
    check("rst_trk_load", 64'(trk_load), 64'd0);
    check("rst_trk_busy", 64'(trk_busy), 64'd0);
    check("rst_trk_prn", 64'(trk_prn), 64'd0);
    check("rst_trk_carr", 64'(trk_carr), 64'd0);
    check("rst_mem_gnt", 64'(mem_gnt), 64'd0);
    check("rst_mem_ptr", 64'(mem_ptr), 64'd0);
    check("rst_trk_dvalid", 64'(trk_dvalid), 64'd0);
    reset = 1'b1;
    wait_start("first_acq_start", 5);

    // Memory arbiter vectors; FSM idles in S_WAIT meanwhile.
    prev_gnt = '0;
    for (int i = 0; i < 12; i++) begin
      trk_req = arb_tbl[i].req;
      cyc();
      check($sformatf("arb_gnt[%0d]", i), 64'(mem_gnt), 64'(arb_tbl[i].gnt));
      check($sformatf("arb_ptr[%0d]", i), 64'(mem_ptr), 64'(arb_tbl[i].ptr));
      check($sformatf("arb_dvalid[%0d]", i), 64'(trk_dvalid), 64'(prev_gnt));
      prev_gnt = arb_tbl[i].gnt;
    end
    trk_req = '0;

    // Results {3,7,0,12}: three loads, slot 2 skipped, then a new acquisition.
    set_results(3, 7, 0, 12);
    expect_load(4'b0001, 0, 3);
    expect_load(4'b0010, 1, 7);
    expect_load(4'b0100, 3, 12);
    acq_complete = 1'b1;
    wait_loads("t1_loads", 20);
    check("t1_busy", 64'(trk_busy), 64'b0111);
    check("t1_restart", 64'(acq_start), 64'd1);
    check("t1_prn_hold", 64'(trk_prn), 64'd12);
    check("t1_code_hold", 64'(trk_code), 64'(code_of(3, 12)));
    acq_complete = 1'b0;
    cyc();
    check("t1_start_cnt", 64'(start_cnt), 64'd2);

    // One free channel, results {5,6,9,11}: only PRN 5 loads, rest discarded.
    set_results(5, 6, 9, 11);
    expect_load(4'b1000, 0, 5);
    acq_complete = 1'b1;
    wait_loads("t3_loads", 20);
    repeat (4) cyc();
    check("t3_busy", 64'(trk_busy), 64'b1111);
    check("t3_prn_hold", 64'(trk_prn), 64'd5);
    check("t3_no_start", 64'(start_cnt), 64'd2);

    // All busy with new results pending: no acquisition until a release.
    acq_complete = 1'b0;
    cyc();
    set_results(20, 21, 22, 23);
    acq_complete = 1'b1;
    repeat (4) cyc();
    check("t2_full_no_start", 64'(start_cnt), 64'd2);
    trk_release = 4'b0100;
    cyc();
    trk_release = '0;
    check("t2_busy", 64'(trk_busy), 64'b1011);
    check("t2_start_early", 64'(acq_start), 64'd0);
    cyc();
    check("t2_start", 64'(acq_start), 64'd1);
    cyc();
    check("t2_start_pulse", 64'(acq_start), 64'd0);

    // acq_complete already high on entry to S_WAIT is not an edge.
    repeat (5) cyc();
    check("stale_level_busy", 64'(trk_busy), 64'b1011);
    check("stale_level_starts", 64'(start_cnt), 64'd3);

    // Release on an idle channel is ignored; then free the rest.
    trk_release = 4'b0100;
    cyc();
    trk_release = '0;
    check("idle_release", 64'(trk_busy), 64'b1011);
    trk_release = 4'b1011;
    cyc();
    trk_release = '0;
    check("release_all", 64'(trk_busy), 64'b0000);
    acq_complete = 1'b0;
    cyc();

    // Channel 0 picks up PRN 7, then results {7,7,4,0}.
    set_results(7, 0, 0, 0);
    expect_load(4'b0001, 0, 7);
    acq_complete = 1'b1;
    wait_loads("dup_prep_loads", 20);
    acq_complete = 1'b0;
    repeat (6) cyc();
    check("dup_prep_busy", 64'(trk_busy), 64'b0001);
    check("dup_prep_starts", 64'(start_cnt), 64'd4);
    set_results(7, 7, 4, 0);
`ifdef DUP_FILTER_EN
    expect_load(4'b0010, 2, 4);
`else
    expect_load(4'b0010, 0, 7);
    expect_load(4'b0100, 1, 7);
    expect_load(4'b1000, 2, 4);
`endif
    acq_complete = 1'b1;
    wait_loads("dup_loads", 20);
    acq_complete = 1'b0;
    repeat (6) cyc();
`ifdef DUP_FILTER_EN
    check("dup_busy", 64'(trk_busy), 64'b0011);
`else
    check("dup_busy", 64'(trk_busy), 64'b1111);
`endif

    // Reset in S_SCAN after the first load.
    trk_release = 4'b1111;
    cyc();
    trk_release = '0;
    repeat (4) cyc();
    check("pre_rst_busy", 64'(trk_busy), 64'd0);
    set_results(1, 2, 3, 4);
    expect_load(4'b0001, 0, 1);
    acq_complete = 1'b1;
    wait_loads("rst_first_load", 20);
    check("rst_mid_load_pending", 64'(trk_load), 64'b0010);
    reset = 1'b0;
    #1;
    check("rst_mid_load", 64'(trk_load), 64'd0);
    check("rst_mid_busy", 64'(trk_busy), 64'd0);
    check("rst_mid_start", 64'(acq_start), 64'd0);
    check("rst_mid_prn", 64'(trk_prn), 64'd0);
    check("rst_mid_mem_ptr", 64'(mem_ptr), 64'd0);
    repeat (2) cyc();
    check("rst_hold_load", 64'(trk_load), 64'd0);
    check("rst_hold_start", 64'(acq_start), 64'd0);
    acq_complete = 1'b0;
    reset = 1'b1;
    wait_start("rst_restart", 5);
    check("rst_restart_busy", 64'(trk_busy), 64'd0);
    repeat (3) cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
